// File: rtl/led_panel_pkg.sv
// Shared types for the HUB75-style LED panel driver.
// FSM state encoding, per-plane colour slice and width helper.
package led_panel_pkg;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    LATCH = 2'd1,
    SHOW  = 2'd2,
    NEXT  = 2'd3
  } state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_bit_t;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_panel_fb.sv
// Pixel frame buffer: one write port, upper/lower half read ports.
// LED_PANEL_DBUF_EN adds a back buffer that swaps on each frame wrap.
module led_panel_fb
  import led_panel_pkg::*;
#(
  parameter int COLS = 32,
  parameter int SCAN = 4,
  parameter int BPC  = 2
) (
  input  logic                        clk,
`ifdef LED_PANEL_DBUF_EN
  input  logic                        reset,
  input  logic                        swap,
`endif
  input  logic                        wr_en,
  input  logic [$clog2(2*SCAN)-1:0]   wr_row,
  input  logic [$clog2(COLS)-1:0]     wr_col,
  input  logic [3*BPC-1:0]            wr_rgb,
  input  logic [$clog2(SCAN)-1:0]     rd_row,
  input  logic [$clog2(COLS)-1:0]     rd_col,
  input  logic [idx_w(BPC)-1:0]       rd_plane,
  output rgb_bit_t                    upper,
  output rgb_bit_t                    lower
);

  localparam int RW = $clog2(2*SCAN);

  logic            wr_ok;
  logic [RW-1:0]   up_row;
  logic [RW-1:0]   lo_row;
  logic [3*BPC-1:0] up_px;
  logic [3*BPC-1:0] lo_px;
  logic [BPC-1:0]  ur, ug, ub;
  logic [BPC-1:0]  lr, lg, lb;

  assign wr_ok  = wr_en && (32'(wr_col) < COLS);
  assign up_row = RW'(rd_row);
  assign lo_row = RW'(rd_row) + RW'(SCAN);

`ifdef LED_PANEL_DBUF_EN
  logic [3*BPC-1:0] mem [2][2*SCAN][COLS];
  logic             front;

  // front selects the displayed buffer; it flips when a frame wraps
  always_ff @(posedge clk) begin
    if (reset)
      front <= 1'b0;
    else if (swap)
      front <= ~front;
  end

  // writes land in the buffer that is not on display
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[~front][wr_row][wr_col] <= wr_rgb;
  end

  assign up_px = mem[front][up_row][rd_col];
  assign lo_px = mem[front][lo_row][rd_col];
`else
  logic [3*BPC-1:0] mem [2*SCAN][COLS];

  // single buffer shared by writer and scan-out; not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_row][wr_col] <= wr_rgb;
  end

  assign up_px = mem[up_row][rd_col];
  assign lo_px = mem[lo_row][rd_col];
`endif

  assign {ur, ug, ub} = up_px;
  assign {lr, lg, lb} = lo_px;

  assign upper = '{r: ur[rd_plane], g: ug[rd_plane], b: ub[rd_plane]};
  assign lower = '{r: lr[rd_plane], g: lg[rd_plane], b: lb[rd_plane]};

endmodule

// File: rtl/led_panel_bcm.sv
// Binary-code-modulation scan driver for a 2*SCAN-row LED panel.
// Optional double buffering via LED_PANEL_DBUF_EN.
module led_panel_bcm
  import led_panel_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int SCAN    = 4,
  parameter int BPC     = 2,
  parameter int BASE_ON = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(2*SCAN)-1:0] wr_row,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [3*BPC-1:0]          wr_rgb,
  output logic [1:0]                red_out,
  output logic [1:0]                green_out,
  output logic [1:0]                blue_out,
  output logic                      sclk_out,
  output logic                      latch_out,
  output logic                      blank_out,
  output logic [$clog2(SCAN)-1:0]   row_addr,
  output logic                      frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN);
  localparam int PW = idx_w(BPC);
  localparam int NW = $clog2((BASE_ON << (BPC-1)) + 1);

  state_t        state;
  logic [CW-1:0] col;
  logic [PW-1:0] plane;
  logic [NW-1:0] cnt;
  logic          shifting;
  logic          last_plane;
  logic          last_row;
  rgb_bit_t      upper;
  rgb_bit_t      lower;

  assign last_plane = (plane == PW'(BPC-1));
  assign last_row   = (row_addr == SW'(SCAN-1));
  assign sclk_out   = shifting ? ~clk : 1'b1;

  led_panel_fb #(
    .COLS (COLS),
    .SCAN (SCAN),
    .BPC  (BPC)
  ) u_fb (
    .clk      (clk),
`ifdef LED_PANEL_DBUF_EN
    .reset    (reset),
    .swap     ((state == NEXT) && last_plane && last_row),
`endif
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_rgb   (wr_rgb),
    .rd_row   (row_addr),
    .rd_col   (col),
    .rd_plane (plane),
    .upper    (upper),
    .lower    (lower)
  );

  // scan FSM: shift a row plane, latch it, show it, advance plane/row
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHIFT;
      col        <= CW'(COLS-1);
      plane      <= '0;
      cnt        <= '0;
      row_addr   <= '0;
      red_out    <= '0;
      green_out  <= '0;
      blue_out   <= '0;
      shifting   <= 1'b0;
      latch_out  <= 1'b0;
      blank_out  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        SHIFT: begin
          red_out   <= {lower.r, upper.r};
          green_out <= {lower.g, upper.g};
          blue_out  <= {lower.b, upper.b};
          shifting  <= 1'b1;
          if (col == '0)
            state <= LATCH;
          else
            col <= col - 1'b1;
        end
        LATCH: begin
          red_out   <= '0;
          green_out <= '0;
          blue_out  <= '0;
          shifting  <= 1'b0;
          latch_out <= 1'b1;
          cnt       <= NW'(BASE_ON) << plane;
          state     <= SHOW;
        end
        SHOW: begin
          latch_out <= 1'b0;
          if (cnt == '0) begin
            blank_out <= 1'b1;
            state     <= NEXT;
          end else begin
            blank_out <= 1'b0;
            cnt       <= cnt - 1'b1;
          end
        end
        NEXT: begin
          col   <= CW'(COLS-1);
          state <= SHIFT;
          if (!last_plane) begin
            plane <= plane + 1'b1;
          end else begin
            plane      <= '0;
            row_addr   <= last_row ? '0 : row_addr + 1'b1;
            frame_done <= last_row;
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel_bcm.sv
// Scoreboard bench for led_panel_bcm (LED_PANEL_DBUF_EN aware).
// Expected scan events are queued per plane and popped by a monitor.
module tb_led_panel_bcm;

  localparam int COLS    = 32;
  localparam int SCAN    = 4;
  localparam int BPC     = 2;
  localparam int BASE_ON = 16;
  localparam int RW = $clog2(2*SCAN);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN);

  localparam int K_SHIFT = 0;
  localparam int K_LATCH = 1;
  localparam int K_SHOW  = 2;
  localparam int K_FD    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [RW-1:0]     wr_row = '0;
  logic [CW-1:0]     wr_col = '0;
  logic [3*BPC-1:0]  wr_rgb = '0;
  logic [1:0]        red_out, green_out, blue_out;
  logic              sclk_out, latch_out, blank_out, frame_done;
  logic [SW-1:0]     row_addr;

  led_panel_bcm #(
    .COLS    (COLS),
    .SCAN    (SCAN),
    .BPC     (BPC),
    .BASE_ON (BASE_ON)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_rgb     (wr_rgb),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .sclk_out   (sclk_out),
    .latch_out  (latch_out),
    .blank_out  (blank_out),
    .row_addr   (row_addr),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int data;
    bit first;
  } rec_t;

  rec_t             sbq[$];
  logic [3*BPC-1:0] img [2][2*SCAN][COLS];
  int               front = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               mon_en = 1'b0;
  int               cyc = 0;
  int               t0 = 0;
  int               run = 0;

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3*BPC-1:0] pat(int r, int c);
    if (r == 0 && c == 31) return 6'b11_00_00;
    if (r == 4 && c == 0)  return 6'b00_10_00;
    if (r == 1 && c == 5)  return 6'b00_00_01;
    if (r == 7 && c == 10) return 6'b01_11_10;
    if (r == 2 && c == 20) return 6'b10_11_01;
    return '0;
  endfunction

  function automatic int frame_len();
    int n = 0;
    for (int r = 0; r < SCAN; r++)
      for (int p = 0; p < BPC; p++)
        n += COLS + 1 + ((BASE_ON << p) + 1) + 1;
    return n;
  endfunction

  task automatic take(int kind, int got, string tag);
    rec_t e;
    if (sbq.size() == 0) begin
      check({tag, "_unexpected"}, kind, -1);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_kind"}, kind, e.kind);
    check(tag, got, e.data);
    if (e.first) t0 = cyc;
  endtask

  // monitor: classify each cycle's outputs and pop the scoreboard
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (!mon_en) begin
      run = 0;
    end else begin
      if (blank_out == 1'b0) begin
        run++;
      end else if (run != 0) begin
        take(K_SHOW, run, "show_len");
        run = 0;
      end
      if (sclk_out == 1'b0) begin
        take(K_SHIFT,
             (int'(row_addr) << 6) | int'({red_out, green_out, blue_out}),
             "shift");
        check("shift_blank", blank_out, 1);
      end
      if (latch_out) begin
        take(K_LATCH, row_addr, "latch_row");
        check("latch_blank", blank_out, 1);
        check("latch_sclk", sclk_out, 1);
        check("latch_rgb", {red_out, green_out, blue_out}, 0);
      end
      if (frame_done) begin
        take(K_FD, cyc - t0, "fd_gap");
        check("fd_row", row_addr, 0);
      end
    end
  end

  task automatic push_plane(int r, int p);
    logic [3*BPC-1:0] up, lo;
    int c6;
    for (int c = COLS-1; c >= 0; c--) begin
      up = img[front][r][c];
      lo = img[front][r+SCAN][c];
      c6 = {lo[2*BPC+p], up[2*BPC+p],
            lo[BPC+p],   up[BPC+p],
            lo[p],       up[p]};
      sbq.push_back('{kind: K_SHIFT, data: (r << 6) | c6,
                      first: (r == 0 && p == 0 && c == COLS-1)});
    end
    sbq.push_back('{kind: K_LATCH, data: r, first: 1'b0});
    sbq.push_back('{kind: K_SHOW, data: BASE_ON << p, first: 1'b0});
    if (r == SCAN-1 && p == BPC-1)
      sbq.push_back('{kind: K_FD, data: frame_len() - 1, first: 1'b0});
  endtask

  task automatic run_frame();
    for (int r = 0; r < SCAN; r++) begin
      for (int p = 0; p < BPC; p++) begin
        int k;
        push_plane(r, p);
        k = 0;
        while (sbq.size() != 0 && k < 400) begin
          @(posedge clk);
          #2;
          k++;
        end
        if (sbq.size() != 0) begin
          check("plane_timeout", sbq.size(), 0);
          sbq.delete();
        end
      end
    end
`ifdef LED_PANEL_DBUF_EN
    front = 1 - front;
`endif
  endtask

  task automatic write_px(int r, int c, logic [3*BPC-1:0] v);
`ifdef LED_PANEL_DBUF_EN
    img[1-front][r][c] = v;
`else
    img[0][r][c] = v;
`endif
    wr_row = RW'(r);
    wr_col = CW'(c);
    wr_rgb = v;
    wr_en  = 1'b1;
    @(posedge clk);
    #2;
    wr_en  = 1'b0;
  endtask

  task automatic fill();
    for (int r = 0; r < 2*SCAN; r++)
      for (int c = 0; c < COLS; c++)
        write_px(r, c, pat(r, c));
  endtask

  task automatic wait_fd();
    int k = 0;
    while (frame_done !== 1'b1 && k < 2000) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("fd_seen", frame_done, 1);
`ifdef LED_PANEL_DBUF_EN
    front = 1 - front;
`endif
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #2;
    check("rst_blank", blank_out, 1);
    check("rst_latch", latch_out, 0);
    check("rst_sclk", sclk_out, 1);
    check("rst_row", row_addr, 0);
    check("rst_fd", frame_done, 0);
    check("rst_rgb", {red_out, green_out, blue_out}, 0);

    fill();
    reset = 1'b0;
    wait_fd();
    fill();
    wait_fd();

    mon_en = 1'b1;
    run_frame();
    run_frame();

    fork
      run_frame();
      begin
        repeat (20) @(posedge clk);
        #2;
        write_px(3, 7, 6'b11_11_11);
      end
    join
    run_frame();

    mon_en = 1'b0;
    k = 0;
    while (blank_out !== 1'b0 && k < 600) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("show_seen", blank_out, 0);
    reset = 1'b1;
    front = 0;
    @(posedge clk);
    #2;
    check("mid_rst_blank", blank_out, 1);
    check("mid_rst_row", row_addr, 0);
    check("mid_rst_latch", latch_out, 0);
    check("mid_rst_sclk", sclk_out, 1);
    check("mid_rst_fd", frame_done, 0);
    check("mid_rst_rgb", {red_out, green_out, blue_out}, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;
    run_frame();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
